// File: rtl/apb_decoder_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_decoder_bridge
// Brief    : APB 1-to-NSLAVES splitter, address-field decode, registered
//            outputs, error completion for unmapped and timed-out accesses.
// Revision : 1.0
// ============================================================================
module apb_decoder_bridge #(
    parameter int          AWIDTH   = 32,
    parameter int          NSLAVES  = 4,
    parameter int          SEL_BITS = 2,
    parameter int          SEL_LSB  = 12,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AWIDTH-1:0]     input_PADDR,
    input  logic                  input_PSEL,
    input  logic                  input_PENABLE,
    input  logic                  input_PWRITE,
    input  logic [31:0]           input_PWDATA,
    output logic                  input_PREADY,
    output logic [31:0]           input_PRDATA,
    output logic                  input_PSLVERROR,
    output logic [AWIDTH-1:0]     output_PADDR,
    output logic [NSLAVES-1:0]    output_PSEL,
    output logic                  output_PENABLE,
    output logic                  output_PWRITE,
    output logic [31:0]           output_PWDATA,
    input  logic [NSLAVES-1:0]    output_PREADY,
    input  logic [NSLAVES*32-1:0] output_PRDATA,
    input  logic [NSLAVES-1:0]    output_PSLVERROR,
    output logic                  timeout_event
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam int                 c_CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0]    c_TMO_LAST = c_CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [SEL_BITS:0]  c_NSLV     = (SEL_BITS + 1)'(NSLAVES);

    logic [1:0]          r_state;
    logic [c_CW-1:0]     r_count;

    logic [SEL_BITS-1:0] w_idx;
    logic                w_mapped;
    logic [NSLAVES-1:0]  w_onehot;
    logic                w_rdy;
    logic                w_serr;
    logic [31:0]         w_srdata;
    logic                w_tmo;

    // The registered one-hot PSEL doubles as the response mux select, so
    // unselected slaves can never leak ready/data/error upstream.
    always_comb begin
        w_idx    = input_PADDR[SEL_LSB +: SEL_BITS];
        w_mapped = ({1'b0, w_idx} < c_NSLV);
        w_onehot = '0;
        w_rdy    = 1'b0;
        w_serr   = 1'b0;
        w_srdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (w_idx == SEL_BITS'(i)) begin
                w_onehot[i] = 1'b1;
            end
            if (output_PSEL[i]) begin
                w_rdy    = w_rdy | output_PREADY[i];
                w_serr   = w_serr | output_PSLVERROR[i];
                w_srdata = w_srdata | output_PRDATA[32*i +: 32];
            end
        end
        // Counter holds the number of not-ready ACCESS cycles already seen;
        // this one is the last allowed when it equals TIMEOUT-1.
        w_tmo = (TIMEOUT != 0) && (r_count == c_TMO_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_count         <= '0;
            input_PREADY    <= 1'b0;
            input_PRDATA    <= '0;
            input_PSLVERROR <= 1'b0;
            output_PADDR    <= '0;
            output_PSEL     <= '0;
            output_PENABLE  <= 1'b0;
            output_PWRITE   <= 1'b0;
            output_PWDATA   <= '0;
            timeout_event   <= 1'b0;
        end else begin
            input_PREADY  <= 1'b0;
            timeout_event <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (input_PSEL && input_PENABLE) begin
                        if (w_mapped) begin
                            output_PADDR   <= input_PADDR;
                            output_PWRITE  <= input_PWRITE;
                            output_PWDATA  <= input_PWDATA;
                            output_PSEL    <= w_onehot;
                            output_PENABLE <= 1'b0;
                            r_count        <= '0;
                            r_state        <= c_SETUP;
                        end else begin
                            input_PREADY    <= 1'b1;
                            input_PRDATA    <= ERR_DATA;
                            input_PSLVERROR <= 1'b1;
                            r_state         <= c_RESP;
                        end
                    end
                end
                c_SETUP: begin
                    output_PENABLE <= 1'b1;
                    r_state        <= c_ACCESS;
                end
                c_ACCESS: begin
                    if (w_rdy) begin
                        input_PREADY    <= 1'b1;
                        input_PRDATA    <= w_srdata;
                        input_PSLVERROR <= w_serr;
                        output_PSEL     <= '0;
                        output_PENABLE  <= 1'b0;
                        r_state         <= c_RESP;
                    end else if (w_tmo) begin
                        input_PREADY    <= 1'b1;
                        input_PRDATA    <= ERR_DATA;
                        input_PSLVERROR <= 1'b1;
                        output_PSEL     <= '0;
                        output_PENABLE  <= 1'b0;
                        timeout_event   <= 1'b1;
                        r_state         <= c_RESP;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_decoder_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apb_decoder_bridge
// Brief    : Self-checking bench for apb_decoder_bridge (3 slaves, TIMEOUT=8).
// Revision : 1.0
// ============================================================================
module tb_apb_decoder_bridge;

    localparam int          NS  = 3;
    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [31:0]     input_PADDR = '0;
    logic            input_PSEL = 1'b0;
    logic            input_PENABLE = 1'b0;
    logic            input_PWRITE = 1'b0;
    logic [31:0]     input_PWDATA = '0;
    logic            input_PREADY;
    logic [31:0]     input_PRDATA;
    logic            input_PSLVERROR;
    logic [31:0]     output_PADDR;
    logic [NS-1:0]   output_PSEL;
    logic            output_PENABLE;
    logic            output_PWRITE;
    logic [31:0]     output_PWDATA;
    logic [NS-1:0]   output_PREADY;
    logic [NS*32-1:0] output_PRDATA;
    logic [NS-1:0]   output_PSLVERROR;
    logic            timeout_event;

    always #5 clk = ~clk;

    apb_decoder_bridge #(
        .AWIDTH(32), .NSLAVES(NS), .SEL_BITS(2), .SEL_LSB(12),
        .TIMEOUT(TMO), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .reset(reset),
        .input_PADDR(input_PADDR), .input_PSEL(input_PSEL),
        .input_PENABLE(input_PENABLE), .input_PWRITE(input_PWRITE),
        .input_PWDATA(input_PWDATA), .input_PREADY(input_PREADY),
        .input_PRDATA(input_PRDATA), .input_PSLVERROR(input_PSLVERROR),
        .output_PADDR(output_PADDR), .output_PSEL(output_PSEL),
        .output_PENABLE(output_PENABLE), .output_PWRITE(output_PWRITE),
        .output_PWDATA(output_PWDATA), .output_PREADY(output_PREADY),
        .output_PRDATA(output_PRDATA), .output_PSLVERROR(output_PSLVERROR),
        .timeout_event(timeout_event)
    );

    // Slave models: selected slave becomes ready after slv_wait ACCESS cycles;
    // unselected slaves shout ready/error with junk data to prove they are ignored.
    int unsigned slv_wait [NS];
    logic [31:0] slv_data [NS];
    logic        slv_err  [NS];
    int unsigned acc_cnt = 0;

    always @(posedge clk) acc_cnt <= output_PENABLE ? acc_cnt + 1 : 0;

    for (genvar g = 0; g < NS; g++) begin : g_slv
        assign output_PREADY[g]        = output_PSEL[g] ? (output_PENABLE && (acc_cnt >= slv_wait[g])) : 1'b1;
        assign output_PRDATA[32*g +: 32] = slv_data[g];
        assign output_PSLVERROR[g]     = slv_err[g];
    end

    // Bus monitor
    logic [NS-1:0] exp_sel = '0;
    logic [31:0]   exp_addr = '0, exp_wdata = '0;
    logic          exp_write = 1'b0;
    int sel_cyc = 0, en_cyc = 0, tmo_cnt = 0, bus_bad = 0, multihot = 0;

    always @(negedge clk) begin
        if (timeout_event) tmo_cnt++;
        if (output_PSEL != '0) sel_cyc++;
        if (output_PENABLE) en_cyc++;
        if ($countones(output_PSEL) > 1) multihot++;
        if (output_PSEL != '0 && (output_PSEL != exp_sel || output_PADDR != exp_addr ||
            output_PWRITE != exp_write || (exp_write && output_PWDATA != exp_wdata)))
            bus_bad++;
        if (output_PENABLE && output_PSEL == '0) bus_bad++;
    end

    int errors = 0, checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: outcome of one upstream access from the bridge's rules.
    function automatic void model(input logic [31:0] addr, input logic wr, input int unsigned wt,
                                  input logic [31:0] sdata, input logic serr,
                                  output logic [31:0] d, output logic e, output logic t,
                                  output int lat, output logic chk);
        int idx;
        idx = int'(addr[13:12]);
        if (idx >= NS) begin
            d = ERR; e = 1'b1; t = 1'b0; lat = 1; chk = 1'b1;
        end else if (TMO != 0 && wt + 1 > TMO) begin
            d = ERR; e = 1'b1; t = 1'b1; lat = 2 + TMO; chk = 1'b1;
        end else begin
            d = sdata; e = serr; t = 1'b0; lat = 3 + int'(wt); chk = !wr;
        end
    endfunction

    task automatic run_xfer(input string nm, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wdata, input int unsigned wt,
                            input logic [31:0] sdata, input logic serr,
                            input logic [31:0] e_data, input logic e_err, input logic e_tmo,
                            input int e_lat, input logic chk_data);
        int idx, lat, s0, e0, t0, b0;
        logic got;
        logic [31:0] rd;
        logic er;
        idx = int'(addr[13:12]);
        for (int i = 0; i < NS; i++) begin
            if (i == idx) begin
                slv_wait[i] = wt; slv_data[i] = sdata; slv_err[i] = serr;
            end else begin
                slv_wait[i] = 0; slv_data[i] = $urandom; slv_err[i] = 1'b1;
            end
        end
        exp_sel = '0;
        if (idx < NS) exp_sel[idx] = 1'b1;
        exp_addr = addr; exp_write = wr; exp_wdata = wdata;
        s0 = sel_cyc; e0 = en_cyc; t0 = tmo_cnt; b0 = bus_bad;
        input_PADDR = addr; input_PWRITE = wr; input_PWDATA = wdata;
        input_PSEL = 1'b1; input_PENABLE = 1'b0;
        @(posedge clk); #1;
        input_PENABLE = 1'b1;
        got = 1'b0; lat = 0; rd = '0; er = 1'b0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(posedge clk); #1;
            if (input_PREADY) begin
                got = 1'b1; lat = n; rd = input_PRDATA; er = input_PSLVERROR;
            end
        end
        input_PSEL = 1'b0; input_PENABLE = 1'b0;
        check({nm, " ready_seen"}, 32'(got), 32'd1);
        check({nm, " latency"}, lat, e_lat);
        check({nm, " pslverror"}, 32'(er), 32'(e_err));
        if (chk_data) check({nm, " prdata"}, rd, e_data);
        @(posedge clk); #1;
        check({nm, " pready_pulse"}, 32'(input_PREADY), 32'd0);
        if (chk_data) check({nm, " prdata_hold"}, input_PRDATA, e_data);
        check({nm, " timeout_events"}, tmo_cnt - t0, 32'(e_tmo));
        check({nm, " psel_cycles"}, sel_cyc - s0, (idx < NS) ? e_lat - 1 : 0);
        check({nm, " penable_cycles"}, en_cyc - e0, (idx < NS) ? e_lat - 2 : 0);
        check({nm, " bus_errors"}, bus_bad - b0, 0);
    endtask

    typedef struct {
        logic [31:0] addr;  logic wr;  logic [31:0] wdata;
        int unsigned wt;    logic [31:0] sdata;  logic serr;
        logic [31:0] e_data; logic e_err; logic e_tmo; int e_lat; logic chk;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, wd, sd, md;
        logic wr, se, me, mt, mc;
        int unsigned wt;
        int ml;

        vecs[0] = '{32'h0000_2004, 1'b0, 32'h0,         0,   32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 3,  1'b1};
        vecs[1] = '{32'h0000_1000, 1'b1, 32'hA5A5_A5A5, 5,   32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 8,  1'b0};
        vecs[2] = '{32'h0000_3000, 1'b0, 32'h0,         0,   32'h0,         1'b0, ERR,           1'b1, 1'b0, 1,  1'b1};
        vecs[3] = '{32'h0000_0010, 1'b0, 32'h0,         255, 32'h1111_1111, 1'b0, ERR,           1'b1, 1'b1, 10, 1'b1};
        vecs[4] = '{32'h0000_0020, 1'b0, 32'h0,         7,   32'hCAFE_0007, 1'b0, 32'hCAFE_0007, 1'b0, 1'b0, 10, 1'b1};
        vecs[5] = '{32'h0000_1008, 1'b0, 32'h0,         1,   32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 4,  1'b1};
        vecs[6] = '{32'h0000_2000, 1'b0, 32'h0,         2,   32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 5,  1'b1};
        vecs[7] = '{32'h0000_3FFC, 1'b1, 32'h0000_0001, 0,   32'h0,         1'b0, ERR,           1'b1, 1'b0, 1,  1'b1};
        vecs[8] = '{32'h0000_2100, 1'b1, 32'h7777_0000, 8,   32'h0,         1'b0, ERR,           1'b1, 1'b1, 10, 1'b1};

        for (int i = 0; i < NS; i++) begin
            slv_wait[i] = 0; slv_data[i] = '0; slv_err[i] = 1'b0;
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset pready", 32'(input_PREADY), 32'd0);
        check("reset prdata", input_PRDATA, 32'd0);
        check("reset pslverror", 32'(input_PSLVERROR), 32'd0);
        check("reset psel", 32'(output_PSEL), 32'd0);
        check("reset penable", 32'(output_PENABLE), 32'd0);
        check("reset timeout_event", 32'(timeout_event), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 9; k++) begin
            run_xfer($sformatf("vec%0d", k), vecs[k].addr, vecs[k].wr, vecs[k].wdata, vecs[k].wt,
                     vecs[k].sdata, vecs[k].serr, vecs[k].e_data, vecs[k].e_err,
                     vecs[k].e_tmo, vecs[k].e_lat, vecs[k].chk);
        end

        // Asynchronous reset in the middle of an ACCESS phase
        slv_wait[1] = 5; slv_data[1] = 32'h1357_9BDF; slv_err[1] = 1'b0;
        exp_sel = 3'b010; exp_addr = 32'h0000_1040; exp_write = 1'b0; exp_wdata = '0;
        input_PADDR = 32'h0000_1040; input_PWRITE = 1'b0; input_PSEL = 1'b1; input_PENABLE = 1'b0;
        @(posedge clk); #1;
        input_PENABLE = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rstmid in_access", 32'(output_PENABLE), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid psel", 32'(output_PSEL), 32'd0);
        check("rstmid penable", 32'(output_PENABLE), 32'd0);
        check("rstmid paddr", output_PADDR, 32'd0);
        check("rstmid pwrite", 32'(output_PWRITE), 32'd0);
        check("rstmid pwdata", output_PWDATA, 32'd0);
        check("rstmid prdata", input_PRDATA, 32'd0);
        check("rstmid pslverror", 32'(input_PSLVERROR), 32'd0);
        check("rstmid pready", 32'(input_PREADY), 32'd0);
        input_PSEL = 1'b0; input_PENABLE = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rstmid no_stale_pready", 32'(input_PREADY), 32'd0);
        run_xfer("post_reset", 32'h0000_1040, 1'b0, 32'h0, 1, 32'h600D_CAFE, 1'b0,
                 32'h600D_CAFE, 1'b0, 1'b0, 4, 1'b1);

        // Randomized accesses against the reference model, with 0..2 idle gaps
        for (int r = 0; r < 40; r++) begin
            a = $urandom;
            a[13:12] = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            wt = $urandom_range(0, 10);
            sd = $urandom;
            se = 1'($urandom_range(0, 1));
            model(a, wr, wt, sd, se, md, me, mt, ml, mc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_xfer($sformatf("rnd%0d", r), a, wr, wd, wt, sd, se, md, me, mt, ml, mc);
        end

        check("psel_never_multihot", multihot, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_decoder_bridge.md
Name: apb_decoder_bridge

Overview:
Single-clock APB splitter. One APB completer port from the CPU-side interconnect fans out to NSLAVES APB requester ports, selected by an address bit-field. All outputs are registered for timing. Unmapped accesses and hung slaves complete with PSLVERROR, so the bus never deadlocks.

Parameters:
AWIDTH, 32, address width of all ports
NSLAVES, 4, number of downstream ports (1..2**SEL_BITS)
SEL_BITS, 2, width of slave-select field
SEL_LSB, 12, lowest address bit of select field; index = PADDR[SEL_LSB +: SEL_BITS]
TIMEOUT, 255, max ACCESS-phase cycles waiting for PREADY; 0 disables timeout
ERR_DATA, 32'h0, PRDATA returned on unmapped/timeout error

Ports:
clk  input  1  single clock
reset  input  1  asynchronous, active-high reset
input_PADDR  input  AWIDTH  upstream address
input_PSEL  input  1  upstream select
input_PENABLE  input  1  upstream enable
input_PWRITE  input  1  upstream write
input_PWDATA  input  32  upstream write data
input_PREADY  output  1  upstream ready, one-cycle pulse
input_PRDATA  output  32  upstream read data
input_PSLVERROR  output  1  upstream error
output_PADDR  output  AWIDTH  shared downstream address (full address, unmodified)
output_PSEL  output  NSLAVES  one-hot downstream select
output_PENABLE  output  1  shared downstream enable
output_PWRITE  output  1  shared downstream write
output_PWDATA  output  32  shared downstream write data
output_PREADY  input  NSLAVES  per-slave ready
output_PRDATA  input  NSLAVES*32  per-slave read data, slave i at [32*i +: 32]
output_PSLVERROR  input  NSLAVES  per-slave error
timeout_event  output  1  one-cycle pulse when a transfer is aborted by timeout

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; timeout counter 0. Reset mid-transfer abandons the transfer silently.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: when input_PSEL & input_PENABLE are sampled high, latch PADDR, PWRITE, PWDATA and decode the index.
  - Mapped (index < NSLAVES): go to SETUP.
  - Unmapped (index >= NSLAVES): go to RESP with PRDATA=ERR_DATA and PSLVERROR=1. No downstream PSEL is asserted.
- SETUP: output_PSEL[index]=1, output_PENABLE=0, latched address/data/write driven. Always lasts one cycle, then ACCESS.
- ACCESS: output_PSEL[index]=1, output_PENABLE=1. Each cycle with output_PREADY[index]=0 increments the counter.
  - output_PREADY[index]=1: capture that slave's PRDATA and PSLVERROR, drop output_PSEL and output_PENABLE on the next edge, go to RESP.
  - TIMEOUT!=0 and counter==TIMEOUT with PREADY still low: abort. Drop PSEL/PENABLE, pulse timeout_event, go to RESP with PRDATA=ERR_DATA and PSLVERROR=1.
  - PREADY arriving in the same cycle the counter reaches TIMEOUT: PREADY wins (normal completion, no timeout_event).
- RESP: input_PREADY=1 for exactly one cycle, then IDLE. The counter clears on entry to SETUP.
- input_PRDATA and input_PSLVERROR hold their value until the next RESP.
- Outputs from non-selected slaves are ignored. output_PSEL is never multi-hot.
- Latency: with a zero-wait slave, input_PREADY rises 3 clk edges after the first upstream access-phase edge.
- Back-to-back: a new upstream access is accepted from the first IDLE cycle after RESP. Because input_PREADY=0 in IDLE, there is no double-issue.
- Upstream PSEL dropped mid-transfer is a protocol violation. The bridge still completes the downstream transfer and pulses input_PREADY.
- Write data is returned as don't-care on input_PRDATA for writes, except on error, where it is ERR_DATA.

Test Plan:
1. Read slave 2 (PADDR=0x2004), zero-wait slave returning 0x12345678 -> output_PSEL=4'b0100 for 2 cycles, PENABLE for 1; input_PREADY 3 edges later, PRDATA=0x12345678, PSLVERROR=0.
2. Write slave 1 with PWDATA=0xA5A5A5A5, slave waits 5 cycles -> output_PWDATA=0xA5A5A5A5 held throughout, single input_PREADY pulse after the slave's PREADY, no timeout_event.
3. NSLAVES=3, PADDR=0x3000 -> no output_PSEL bit ever set; input_PREADY after 1 cycle, PSLVERROR=1, PRDATA=ERR_DATA.
4. TIMEOUT=8, slave 0 never ready -> exactly 8 ACCESS cycles, timeout_event pulse, PSLVERROR=1, FSM back to IDLE. Repeat with PREADY on cycle 8 -> normal completion, no timeout_event.
5. Slave returns PSLVERROR=1 with data 0x55 -> input_PSLVERROR=1, PRDATA=0x55. Next clean access -> PSLVERROR=0.
6. Assert reset during ACCESS -> all outputs 0 immediately (async). After release, a new transfer completes normally.
